// File: rtl/mimc_feistel_decipher_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : galois_pow_5
//  Description : Computes base^5 mod PRIME with a bit-serial (MSB-first)
//                double-and-add modular multiplier. It performs three
//                multiplications in sequence: x^2, x^4 = (x^2)^2 and
//                x^5 = x^4 * x. Each multiplication takes N_BITS cycles.
//  Ports       : clk       clock, rising edge
//                rst_n     asynchronous reset, active-low
//                i_srst    synchronous hold-in-reset, effective when i_en=1;
//                          it also loads i_base
//                i_en      clock enable
//                i_base    operand x (< PRIME)
//                o_result  x^5 mod PRIME, valid when o_done pulses
//                o_done    one-cycle pulse when o_result is updated
//  Revision    : 1.0 - initial release
// ============================================================================
module galois_pow_5 #(
    parameter int                N_BITS             = 254,
    parameter logic [N_BITS-1:0] PRIME              = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter                    GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_srst,
    input  logic              i_en,
    input  logic [N_BITS-1:0] i_base,
    output logic [N_BITS-1:0] o_result,
    output logic              o_done
);

    localparam int              c_CW       = $clog2(N_BITS);
    localparam logic [c_CW-1:0] c_CNT_TOP  = c_CW'(N_BITS - 1);

    // Multiplication phases
    localparam logic [1:0] c_PH_SQ    = 2'd0;  // x * x
    localparam logic [1:0] c_PH_QUAD  = 2'd1;  // x^2 * x^2
    localparam logic [1:0] c_PH_FIFTH = 2'd2;  // x^4 * x
    localparam logic [1:0] c_PH_IDLE  = 2'd3;

    // Only the double-and-add multiplier is implemented
    generate
        if (GALOIS_MULT_METHOD != "peasant") begin : g_method_check
            $error("galois_pow_5: unsupported GALOIS_MULT_METHOD");
        end
    endgenerate

    function automatic logic [N_BITS-1:0] f_add_mod(input logic [N_BITS-1:0] a,
                                                    input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME})
            s = s - {1'b0, PRIME};
        return s[N_BITS-1:0];
    endfunction

    logic [N_BITS-1:0] r_x;
    logic [N_BITS-1:0] r_a;
    logic [N_BITS-1:0] r_b;
    logic [N_BITS-1:0] r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [1:0]        r_phase;

    logic [N_BITS-1:0] w_dbl;
    logic [N_BITS-1:0] w_step;

    // One step of MSB-first multiplication: acc = 2*acc (+ a if b[cnt])
    always_comb begin
        w_dbl  = f_add_mod(r_acc, r_acc);
        w_step = r_b[r_cnt] ? f_add_mod(w_dbl, r_a) : w_dbl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= c_CNT_TOP;
            r_phase  <= c_PH_IDLE;
            o_result <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_en) begin
                if (i_srst) begin
                    r_x     <= i_base;
                    r_a     <= i_base;
                    r_b     <= i_base;
                    r_acc   <= '0;
                    r_cnt   <= c_CNT_TOP;
                    r_phase <= c_PH_SQ;
                end else if (r_phase != c_PH_IDLE) begin
                    if (r_cnt != '0) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Last bit of a product: w_step is the finished product
                        r_acc <= '0;
                        r_cnt <= c_CNT_TOP;
                        case (r_phase)
                            c_PH_SQ: begin
                                r_a     <= w_step;
                                r_b     <= w_step;
                                r_phase <= c_PH_QUAD;
                            end
                            c_PH_QUAD: begin
                                r_a     <= w_step;
                                r_b     <= r_x;
                                r_phase <= c_PH_FIFTH;
                            end
                            c_PH_FIFTH: begin
                                o_result <= w_step;
                                o_done   <= 1'b1;
                                r_phase  <= c_PH_IDLE;
                            end
                            default: r_phase <= c_PH_IDLE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// ============================================================================
//  Module      : mimc_feistel_decipher_round
//  Description : One inverse round of the MiMC-5 Feistel cipher over
//                GF(PRIME). Undoes one forward round; key = 0 inverts one
//                round of the MiMC Feistel permutation.
//  Ports       : clk             clock, rising edge
//                rst_n           asynchronous reset, active-low
//                start           request, sampled only in IDLE
//                in_left/right   L', R' of the forward-round output
//                round_constant  c used by the forward round
//                key             k
//                is_last_round   forward round was the non-swapping last one
//                busy            high from accepted start until done
//                out_left/right  recovered L, R (registered)
//                done            one-cycle result-valid pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mimc_feistel_decipher_round #(
    parameter int                N_BITS             = 254,
    parameter logic [N_BITS-1:0] PRIME              = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter                    GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] in_left,
    input  logic [N_BITS-1:0] in_right,
    input  logic [N_BITS-1:0] round_constant,
    input  logic [N_BITS-1:0] key,
    input  logic              is_last_round,
    output logic              busy,
    output logic [N_BITS-1:0] out_left,
    output logic [N_BITS-1:0] out_right,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_POW  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    function automatic logic [N_BITS-1:0] f_add_mod(input logic [N_BITS-1:0] a,
                                                    input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME})
            s = s - {1'b0, PRIME};
        return s[N_BITS-1:0];
    endfunction

    // a - b mod PRIME; the (N_BITS+1)-bit wrap of a-b is fixed by adding PRIME
    function automatic logic [N_BITS-1:0] f_sub_mod(input logic [N_BITS-1:0] a,
                                                    input logic [N_BITS-1:0] b);
        logic [N_BITS:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b)
            d = d + {1'b0, PRIME};
        return d[N_BITS-1:0];
    endfunction

    state_t            r_state;
    logic [N_BITS-1:0] r_left;
    logic [N_BITS-1:0] r_right;
    logic [N_BITS-1:0] r_const;
    logic [N_BITS-1:0] r_key;
    logic              r_last;

    logic [N_BITS-1:0] w_base;
    logic [N_BITS-1:0] w_keep;
    logic [N_BITS-1:0] w_minuend;
    logic [N_BITS-1:0] w_pow_result;
    logic              w_pow_done;
    logic              w_pow_srst;
    logic              w_pow_en;

    // The half that passed through unchanged feeds the round function;
    // the other half had the pow added and gets it subtracted back.
    always_comb begin
        w_keep     = r_last ? r_left  : r_right;
        w_minuend  = r_last ? r_right : r_left;
        w_base     = f_add_mod(f_add_mod(w_keep, r_const), r_key);
        w_pow_srst = (r_state == S_LOAD);
        w_pow_en   = (r_state == S_LOAD) || (r_state == S_POW);
    end

    galois_pow_5 #(
        .N_BITS             (N_BITS),
        .PRIME              (PRIME),
        .GALOIS_MULT_METHOD (GALOIS_MULT_METHOD)
    ) u_pow (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_srst   (w_pow_srst),
        .i_en     (w_pow_en),
        .i_base   (w_base),
        .o_result (w_pow_result),
        .o_done   (w_pow_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_left    <= '0;
            r_right   <= '0;
            r_const   <= '0;
            r_key     <= '0;
            r_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_left  <= in_left;
                        r_right <= in_right;
                        r_const <= round_constant;
                        r_key   <= key;
                        r_last  <= is_last_round;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_POW;
                end
                S_POW: begin
                    if (w_pow_done) begin
                        out_left  <= w_keep;
                        out_right <= f_sub_mod(w_minuend, w_pow_result);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_FIN;
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
